// File: rtl/plot_sink_if.sv
// rtl/plot_sink_if.sv - plot request and framebuffer write bundle for plot_sink
interface plot_sink_if #(
    parameter int COLOUR_W = 6,
    parameter int ADDR_W   = 15
);
    logic [7:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [COLOUR_W-1:0] mem_data;
    logic                mem_wren;
    logic                mem_grant;
    logic                busy;
    logic [7:0]          drop_count;

    // master: plot writer plus scanout grant source; slave: the sink itself
    modport master (
        output x, y, colour, plot, mem_grant,
        input  ready, mem_addr, mem_data, mem_wren, busy, drop_count
    );

    modport slave (
        input  x, y, colour, plot, mem_grant,
        output ready, mem_addr, mem_data, mem_wren, busy, drop_count
    );
endinterface

// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - buffers pixel plot requests and turns them into linear framebuffer writes
module plot_sink #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int COLOUR_W   = 6,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    plot_sink_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 16 + COLOUR_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     X_LIM    = 8'(H_RES);
    localparam logic [7:0]     Y_LIM    = 8'(V_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ENTRY_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [7:0]          x_r_q, x_r_d;
    logic [7:0]          y_r_q, y_r_d;
    logic [COLOUR_W-1:0] c_r_q, c_r_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COLOUR_W-1:0] data_q, data_d;
    logic [7:0]          drop_q, drop_d;

    logic                ready;
    logic                fifo_empty;
    logic                accept;
    logic                in_range;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   lin_addr;

    assign ready      = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign accept     = bus.plot && ready;
    assign in_range   = (bus.x < X_LIM) && (bus.y < Y_LIM);
    assign push       = accept && in_range;
    assign head       = fifo_q[rd_ptr_q];

    // Widen before multiplying so y*H_RES never wraps at 8 bits.
    assign lin_addr = ADDR_W'(y_r_q) * ADDR_W'(H_RES) + ADDR_W'(x_r_q);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.mem_grant) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        x_r_d    = x_r_q;
        y_r_d    = y_r_q;
        c_r_d    = c_r_q;
        addr_d   = addr_q;
        data_d   = data_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            x_r_d    = head[ENTRY_W-1 -: 8];
            y_r_d    = head[ENTRY_W-9 -: 8];
            c_r_d    = head[COLOUR_W-1:0];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (state_q == S_LOAD) begin
            addr_d = lin_addr;
            data_d = c_r_q;
        end

        // Out-of-range requests still complete the handshake; only the tally moves.
        if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            x_r_q    <= '0;
            y_r_q    <= '0;
            c_r_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            x_r_q    <= x_r_d;
            y_r_q    <= y_r_d;
            c_r_q    <= c_r_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.x, bus.y, bus.colour};
        end
    end

    assign bus.ready      = ready;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign bus.mem_wren   = (state_q == S_WRITE) && bus.mem_grant;
    assign bus.busy       = !fifo_empty || (state_q != S_IDLE);
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - self-checking bench for plot_sink
module tb_plot_sink;
    typedef struct packed {
        logic [14:0] addr;
        logic [5:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [5:0]  c;
        bit          in_range;
        logic [14:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    int   write_cnt = 0;
    int   exp_drop = 0;
    wr_t  sb[$];
    vec_t vecs[11];

    plot_sink_if #(.COLOUR_W(6), .ADDR_W(15)) bif ();

    plot_sink #(
        .H_RES(160), .V_RES(120), .COLOUR_W(6), .ADDR_W(15), .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bif.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, 32'(bif.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic plot_once(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        bif.x = x;
        bif.y = y;
        bif.colour = c;
        bif.plot = 1'b1;
        step();
        bif.plot = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn && bif.mem_wren) begin
            wr_t e;
            write_cnt++;
            chk("wren_without_grant", 32'(bif.mem_grant), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 32'(bif.mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bif.mem_addr), 32'(e.addr));
                chk("wr_data", 32'(bif.mem_data), 32'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        vecs[0]  = '{8'd76,  8'd29,  6'h30, 1'b1, 15'd4716};
        vecs[1]  = '{8'd159, 8'd119, 6'h3F, 1'b1, 15'd19199};
        vecs[2]  = '{8'd0,   8'd0,   6'h01, 1'b1, 15'd0};
        vecs[3]  = '{8'd160, 8'd0,   6'h11, 1'b0, 15'd0};
        vecs[4]  = '{8'd0,   8'd120, 6'h22, 1'b0, 15'd0};
        vecs[5]  = '{8'd255, 8'd255, 6'h33, 1'b0, 15'd0};
        vecs[6]  = '{8'd10,  8'd1,   6'h2A, 1'b1, 15'd170};
        vecs[7]  = '{8'd159, 8'd0,   6'h15, 1'b1, 15'd159};
        vecs[8]  = '{8'd0,   8'd119, 6'h0C, 1'b1, 15'd19040};
        vecs[9]  = '{8'd100, 8'd50,  6'h33, 1'b1, 15'd8100};
        vecs[10] = '{8'd159, 8'd120, 6'h07, 1'b0, 15'd0};

        resetn = 1'b0;
        bif.x = '0;
        bif.y = '0;
        bif.colour = '0;
        bif.plot = 1'b0;
        bif.mem_grant = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bif.ready), 32'd1);
        chk("rst_wren", 32'(bif.mem_wren), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_addr", 32'(bif.mem_addr), 32'd0);
        chk("rst_data", 32'(bif.mem_data), 32'd0);
        chk("rst_drop", 32'(bif.drop_count), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // single write with exact latency
        bif.mem_grant = 1'b1;
        w0 = write_cnt;
        sb.push_back('{15'd4716, 6'h30});
        plot_once(8'd76, 8'd29, 6'b110000);
        @(negedge clk); chk("lat_k0", 32'(bif.mem_wren), 32'd0);
        @(negedge clk); chk("lat_k1", 32'(bif.mem_wren), 32'd0);
        @(negedge clk); chk("lat_k2", 32'(bif.mem_wren), 32'd1);
        @(negedge clk); chk("lat_k3", 32'(bif.mem_wren), 32'd0);
        wait_idle("t1");
        chk("t1_one_write", 32'(write_cnt - w0), 32'd1);

        // two out-of-range plots back to back
        w0 = write_cnt;
        bif.x = 8'd160; bif.y = 8'd0; bif.plot = 1'b1;
        step();
        bif.x = 8'd0; bif.y = 8'd120;
        step();
        bif.plot = 1'b0;
        exp_drop += 2;
        @(negedge clk);
        chk("t2_ready", 32'(bif.ready), 32'd1);
        wait_idle("t2");
        repeat (3) @(negedge clk);
        chk("t2_drop", 32'(bif.drop_count), 32'(exp_drop));
        chk("t2_no_write", 32'(write_cnt - w0), 32'd0);
        step();

        // table of single plots, each drained before the next
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].in_range) sb.push_back('{vecs[i].addr, vecs[i].c});
            else exp_drop++;
            plot_once(vecs[i].x, vecs[i].y, vecs[i].c);
            wait_idle("vec");
            chk($sformatf("vec%0d_drop", i), 32'(bif.drop_count), 32'(exp_drop));
            chk($sformatf("vec%0d_ready", i), 32'(bif.ready), 32'd1);
        end

        // fill under stalled grant, then drain at one write per two cycles
        bif.mem_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bif.x = 8'(i * 10 + 1);
            bif.y = 8'(i + 1);
            bif.colour = 6'(i + 1);
            bif.plot = 1'b1;
            @(negedge clk);
            chk($sformatf("t3_ready_before_%0d", i), 32'(bif.ready), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) sb.push_back('{15'((i + 1) * 160 + i * 10 + 1), 6'(i + 1)});
            step();
        end
        bif.plot = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", 32'(bif.ready), 32'd0);
            chk("t3_stall_busy", 32'(bif.busy), 32'd1);
        end
        chk("t3_queued", 32'(sb.size()), 32'd5);
        w0 = write_cnt;
        @(posedge clk);
        #1;
        bif.mem_grant = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("t3_wren_c%0d", i), 32'(bif.mem_wren), (i % 2 == 0 && i < 10) ? 32'd1 : 32'd0);
            if (i == 1) chk("t3_ready_after_pop", 32'(bif.ready), 32'd1);
        end
        wait_idle("t3");
        chk("t3_write_count", 32'(write_cnt - w0), 32'd5);

        // reset while requests are queued
        bif.mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{15'(i * 160 + 5), 6'h2});
            plot_once(8'd5, 8'(i), 6'h2);
        end
        step();
        w0 = write_cnt;
        resetn = 1'b0;
        sb.delete();
        exp_drop = 0;
        #1;
        bif.mem_grant = 1'b1;
        #1;
        chk("t5_rst_wren", 32'(bif.mem_wren), 32'd0);
        chk("t5_rst_busy", 32'(bif.busy), 32'd0);
        chk("t5_rst_ready", 32'(bif.ready), 32'd1);
        chk("t5_rst_addr", 32'(bif.mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_no_write", 32'(write_cnt - w0), 32'd0);
        chk("t5_busy", 32'(bif.busy), 32'd0);
        chk("t5_drop", 32'(bif.drop_count), 32'(exp_drop));
        step();

        // drop counter saturation
        bif.x = 8'd200; bif.y = 8'd5; bif.colour = 6'h1; bif.plot = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (exp_drop < 255) exp_drop++;
        end
        bif.plot = 1'b0;
        @(negedge clk);
        chk("t6_ready", 32'(bif.ready), 32'd1);
        chk("t6_drop_sat", 32'(bif.drop_count), 32'(exp_drop));
        plot_once(8'd170, 8'd0, 6'h1);
        repeat (3) @(negedge clk);
        chk("t6_drop_hold", 32'(bif.drop_count), 32'd255);
        step();
        sb.push_back('{15'd323, 6'h15});
        w0 = write_cnt;
        plot_once(8'd3, 8'd2, 6'h15);
        wait_idle("t6");
        chk("t6_valid_write", 32'(write_cnt - w0), 32'd1);
        chk("t6_drop_final", 32'(bif.drop_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
